bus_transfer_ctrl: RTL and testbench

//  Sequencer that sits directly upstream of the register file on the shared
//  tri-state data bus and drives every register's en/set pair. It accepts one
//  "move src -> dst" request at a time and runs a fixed enable/set/hold

---
 rtl/bus_transfer_ctrl_if.sv | 27 ++
 rtl/bus_transfer_ctrl.sv | 82 ++++++++
 tb/tb_bus_transfer_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bus_transfer_ctrl_if.sv
// Request/strobe bundle between a bus master and the transfer sequencer.
// The tri-state data bus itself is a plain port on the sequencer.
interface bus_transfer_ctrl_if #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 4
);
    logic                req;
    logic [IDX_W-1:0]    src;
    logic [IDX_W-1:0]    dst;
    logic [WIDTH-1:0]    imm;
    logic                ready;
    logic                done;
    logic                err;
    logic [NUM_REGS-1:0] reg_en;
    logic [NUM_REGS-1:0] reg_set;

    modport master (
        output req, src, dst, imm,
        input  ready, done, err, reg_en, reg_set
    );

    modport slave (
        input  req, src, dst, imm,
        output ready, done, err, reg_en, reg_set
    );
endinterface

// File: rtl/bus_transfer_ctrl.sv
// Register-file bus sequencer: runs drive/latch/hold for one move at a time.
// Exactly one source drives the bus while the destination strobe fires.
module bus_transfer_ctrl #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    bus_transfer_ctrl_if.slave bus,
    output logic [WIDTH-1:0] bus_out
);
    localparam logic [IDX_W-1:0]    NREG = IDX_W'(NUM_REGS);
    localparam logic [NUM_REGS-1:0] ONE  = NUM_REGS'(1);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        LATCH,
        HOLD,
        DONE,
        ERR
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] src_q;
    logic [IDX_W-1:0] dst_q;
    logic [WIDTH-1:0] imm_q;
    logic             accept;
    logic             valid;
    logic             src_on;
    logic             imm_src;

    assign accept = (state == IDLE) && bus.req;
    assign valid  = (bus.dst < NREG) && (bus.src <= NREG)
                 && (bus.src != bus.dst);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            imm_q <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                src_q <= bus.src;
                dst_q <= bus.dst;
                imm_q <= bus.imm;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.req) state_nx = valid ? DRIVE : ERR;
            DRIVE:   state_nx = LATCH;
            LATCH:   state_nx = HOLD;
            HOLD:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes decode from state and latched fields only, never from req/src/dst.
    always_comb begin
        src_on      = (state == DRIVE) || (state == LATCH) || (state == HOLD);
        imm_src     = (src_q == NREG);
        bus.ready   = (state == IDLE);
        bus.done    = (state == DONE);
        bus.err     = (state == ERR);
        bus.reg_en  = '0;
        bus.reg_set = '0;
        if (src_on && !imm_src) bus.reg_en = ONE << src_q;
        if (state == LATCH) bus.reg_set = ONE << dst_q;
    end

    assign bus_out = (src_on && imm_src) ? imm_q : {WIDTH{1'bz}};
endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Directed and randomised checks of bus_transfer_ctrl against a
// transaction-age model of the move sequence.
module tb_bus_transfer_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    wire  [15:0] bus_out;

    bus_transfer_ctrl_if #(.WIDTH(16), .NUM_REGS(8), .IDX_W(4)) bif ();

    bus_transfer_ctrl #(.WIDTH(16), .NUM_REGS(8), .IDX_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bif),
        .bus_out (bus_out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // model: one transaction in flight, age = cycles since accept edge
    bit          m_act = 0;
    bit          m_ok = 0;
    int          m_src = 0;
    int          m_dst = 0;
    logic [15:0] m_imm = '0;
    int          m_age = 0;
    int          accepted = 0;
    int          completions = 0;
    int          rnd_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit          drv;
        logic [7:0]  e_en;
        logic [7:0]  e_set;
        logic [15:0] e_bus;
        drv   = m_act && m_ok && m_age >= 1 && m_age <= 3;
        e_en  = (drv && m_src < 8) ? 8'(1 << m_src) : 8'h00;
        e_set = (m_act && m_ok && m_age == 2) ? 8'(1 << m_dst) : 8'h00;
        e_bus = (drv && m_src == 8) ? m_imm : 16'hzzzz;
        chk("ready", 32'(bif.ready), 32'(!m_act));
        chk("done", 32'(bif.done), 32'(m_act && m_ok && m_age == 4));
        chk("err", 32'(bif.err), 32'(m_act && !m_ok && m_age == 1));
        chk("reg_en", {24'h0, bif.reg_en}, {24'h0, e_en});
        chk("reg_set", {24'h0, bif.reg_set}, {24'h0, e_set});
        chk("bus_out", {16'h0, bus_out}, {16'h0, e_bus});
        chk("inv_en_onehot", 32'($onehot0(bif.reg_en)), 32'd1);
        chk("inv_set_onehot", 32'($onehot0(bif.reg_set)), 32'd1);
        if (bif.done || bif.err) completions++;
    endtask

    // apply inputs at negedge, update model at posedge, check at next negedge
    task automatic cyc(input bit rst, input bit rq, input int s,
                       input int d, input logic [15:0] im);
        rst_n   = !rst;
        bif.req = rq;
        bif.src = 4'(s);
        bif.dst = 4'(d);
        bif.imm = im;
        @(posedge clk);
        if (rst) begin
            if (m_act) accepted--;
            m_act = 0;
        end else if (m_act) begin
            m_age++;
            if ((m_ok && m_age == 5) || (!m_ok && m_age == 2)) m_act = 0;
        end else if (rq) begin
            m_act = 1;
            m_age = 1;
            m_src = s;
            m_dst = d;
            m_imm = im;
            m_ok  = (d < 8) && (s <= 8) && (s != d);
            accepted++;
            rnd_acc++;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        bif.req = 0;
        bif.src = '0;
        bif.dst = '0;
        bif.imm = '0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 16'h0);
        cyc(1, 1, 2, 5, 16'h1234);
        chk("reset_ready", 32'(bif.ready), 32'd1);

        // register move 2 -> 5
        cyc(0, 1, 2, 5, 16'h0);
        chk("t1_en_c1", {24'h0, bif.reg_en}, 32'h04);
        cyc(0, 0, 0, 0, 16'h0);
        chk("t1_set_c2", {24'h0, bif.reg_set}, 32'h20);
        idle(2);
        chk("t1_done_c4", 32'(bif.done), 32'd1);
        idle(1);
        chk("t1_ready_c5", 32'(bif.ready), 32'd1);

        // immediate move into reg 0
        cyc(0, 1, 8, 0, 16'hBEEF);
        chk("t2_bus_c1", {16'h0, bus_out}, 32'hBEEF);
        idle(5);

        // rejected requests
        cyc(0, 1, 3, 3, 16'h0);
        chk("t3_err_same", 32'(bif.err), 32'd1);
        idle(1);
        cyc(0, 1, 1, 9, 16'h0);
        idle(1);
        cyc(0, 1, 10, 1, 16'h0);
        idle(1);

        // req held high with changing fields
        for (int i = 0; i < 20; i++)
            cyc(0, 1, i % 8, (i + 3) % 8, 16'(i * 77));
        idle(5);

        // reset landing on the LATCH cycle
        cyc(0, 1, 4, 6, 16'h0);
        cyc(0, 0, 0, 0, 16'h0);
        cyc(1, 0, 0, 0, 16'h0);
        chk("t5_rst_en", {24'h0, bif.reg_en}, 32'h0);
        idle(1);
        cyc(0, 1, 6, 1, 16'h0);
        idle(5);

        // randomised traffic
        rnd_acc = 0;
        for (int n = 0; n < 20000 && rnd_acc < 1000; n++) begin
            int s;
            int d;
            s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15))
                                            : int'($urandom_range(0, 8));
            d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15))
                                            : int'($urandom_range(0, 7));
            cyc(0, $urandom_range(0, 3) != 0, s, d, 16'($urandom));
        end
        chk("rnd_accepted", 32'(rnd_acc), 32'd1000);
        idle(6);
        chk("done_err_total", 32'(completions), 32'(accepted));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
